v1_peak_detector: RTL and testbench
===================================

Name: v1_peak_detector

Overview:
- Sits directly downstream of the v1 trapezoidal filter and consumes its free-running filtered stream, one sample per clk.
- Detects threshold-crossing pulses and captures the pulse maximum (amplitude) with a timestamp.
- Presents each event as one amplitude/timestamp record over a valid/ready handshake to the readout stage.
- Applies a programmable hold-off after each pulse and counts events lost to back-pressure.

Parameters:
- THRESHOLD, 100, signed trigger level; a sample arms the detector only if strictly greater.
- HOLDOFF_CYCLES, 8, dead cycles after each pulse ends; 0 means return straight to IDLE.
- TS_W, 32, timestamp counter width.
- MAX_WIDTH, 64, pile-up width limit in samples; used only with V1_PEAK_PILEUP_REJECT_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  SIZE_FILTER_DATA  filter output, signed two's complement, valid every cycle.
- out_amplitude  out  SIZE_FILTER_DATA  pulse maximum, signed.
- out_timestamp  out  TS_W  timestamp of the first sample that reached the maximum.
- out_valid  out  1  record available.
- out_ready  in  1  consumer accepts the record.
- drop_count  out  16  events lost because the output slot was full; saturating.
- pileup_count  out  16  events rejected as pile-up; saturating; tied to 0 without the macro.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, overrides everything): state=IDLE; ts, max, max_ts, width, holdoff counter, drop_count, pileup_count, out_amplitude, out_timestamp = 0; out_valid=0. Reset mid-pulse discards the pulse and emits no record.
- ts: free-running, +1 every clk, wraps modulo 2^TS_W; wrap has no other effect.
- All comparisons are signed at SIZE_FILTER_DATA width.
- IDLE:
  - if in_data > THRESHOLD: max<=in_data, max_ts<=ts, width<=1, go to ARMED.
  - otherwise stay in IDLE.
- ARMED:
  - width increments each cycle, saturating at all-ones.
  - if in_data > max: update max and max_ts. On ties, the earlier sample is kept.
  - if in_data <= THRESHOLD: go to EMIT; this sample is not compared against max.
- EMIT (exactly one cycle):
  - output slot is free when (!out_valid || out_ready).
  - if free: out_amplitude<=max, out_timestamp<=max_ts, out_valid<=1.
  - if not free: drop_count+1 (saturating); the existing record is left untouched.
  - next state: HOLDOFF with counter=HOLDOFF_CYCLES, or IDLE if HOLDOFF_CYCLES==0.
- HOLDOFF: in_data is ignored; counter decrements; go to IDLE the cycle after the counter reaches 1.
- Handshake:
  - out_valid stays high and the record stays stable until a cycle with out_ready=1.
  - that cycle clears out_valid, unless EMIT loads a new record in the same cycle, in which case out_valid stays 1 with new data.
  - out_ready while out_valid=0 has no effect.
- Latency: the below-threshold sample registered at edge n moves the FSM to EMIT; out_valid is high after edge n+1.
- Minimum event spacing: 2 + HOLDOFF_CYCLES cycles from pulse end to re-arm.

Optional Feature:
- Macro: V1_PEAK_PILEUP_REJECT_EN.
- With the macro defined:
  - in ARMED, if width reaches MAX_WIDTH while still above THRESHOLD: pileup_count+1 (saturating), no record is emitted.
  - go to HOLDOFF, then stay in a WAIT_LOW state until in_data <= THRESHOLD before returning to IDLE.
- Without the macro: pulses of any width are emitted normally; pileup_count is constant 0 and MAX_WIDTH is unused.

Decomposition:
- package_settings (existing) supplies SIZE_FILTER_DATA.
- New package v1_peak_params holds:
  - the state enum (IDLE, ARMED, EMIT, HOLDOFF, WAIT_LOW);
  - defaults for THRESHOLD, HOLDOFF_CYCLES, TS_W, MAX_WIDTH;
  - the record struct {amplitude, timestamp}.
- One sub-module, v1_peak_out_slot: a single-entry valid/ready holding register with drop counting. The FSM and max tracking stay in the top module.

Test Plan:
- Single pulse, THRESHOLD=100, HOLDOFF=8, out_ready=1. Input starting at ts=10: 0,50,150,300,250,120,90,0… → one record amp=300, ts=13; out_valid high 2 cycles after the 90 sample is presented, for one cycle.
- Plateau 200,300,300,300,50 starting at ts=20 → amp=300, ts=21 (first maximum wins).
- Back-pressure: out_ready=0 and two pulses (peaks 300, then 400) separated by more than 10 cycles → the first record is held unchanged, drop_count=1. Asserting out_ready then clears out_valid the next cycle.
- Hold-off: a second pulse crossing 3 cycles after pulse end with HOLDOFF_CYCLES=8 is ignored; the same pulse at 12 cycles is recorded.
- Reset asserted mid-pulse (in ARMED), then released with input at 0 → no record, all outputs 0, busy=0; the next pulse is detected normally.
- With V1_PEAK_PILEUP_REJECT_EN and MAX_WIDTH=4: 6 consecutive samples of 500 → no record, pileup_count=1, no re-arm until the input drops to ≤100.

Source files
------------

// File: rtl/package_settings.sv
// ---------------------------------------------------------------------------
// package_settings
// Project-wide data-path sizing shared by the v1 acquisition chain.
//   SIZE_FILTER_DATA : width of the trapezoidal filter output sample.
// ---------------------------------------------------------------------------
package package_settings;
  localparam int SIZE_FILTER_DATA = 16;
endpackage

// File: rtl/v1_peak_params.sv
// ---------------------------------------------------------------------------
// v1_peak_params
// Shared definitions for the v1 peak detector:
//   peak_state_t : FSM states.
//   *_DEF        : default values for the detector parameters.
//   peak_rec_t   : amplitude/timestamp event record at the default TS width.
// ---------------------------------------------------------------------------
package v1_peak_params;
  import package_settings::*;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    EMIT     = 3'd2,
    HOLDOFF  = 3'd3,
    WAIT_LOW = 3'd4
  } peak_state_t;

  localparam int THRESHOLD_DEF      = 100;
  localparam int HOLDOFF_CYCLES_DEF = 8;
  localparam int TS_W_DEF           = 32;
  localparam int MAX_WIDTH_DEF      = 64;

  // Pulse width and hold-off counters; width saturates at all-ones.
  localparam int CNT_W = 16;

  typedef struct packed {
    logic signed [SIZE_FILTER_DATA-1:0] amplitude;
    logic        [TS_W_DEF-1:0]         timestamp;
  } peak_rec_t;
endpackage

// File: rtl/v1_peak_out_slot.sv
// ---------------------------------------------------------------------------
// v1_peak_out_slot
// Single-entry valid/ready holding register for event records.
//   clk, reset   : clock, synchronous active-high reset
//   load_i       : offer a new record this cycle
//   rec_i        : record offered
//   ready_i      : consumer accepts the held record
//   valid_o      : a record is held
//   rec_o        : held record (stable while valid_o && !ready_i)
//   drop_count_o : saturating count of offers refused because the slot was full
// ---------------------------------------------------------------------------
module v1_peak_out_slot
  import v1_peak_params::*;
#(
  parameter type rec_t = peak_rec_t
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  rec_t        rec_i,
  input  logic        ready_i,
  output logic        valid_o,
  output rec_t        rec_o,
  output logic [15:0] drop_count_o
);

  logic        valid_q;
  rec_t        rec_q;
  logic [15:0] drop_q;
  logic        free;

  // Slot can take a record if empty or being drained this very cycle.
  assign free = !valid_q || ready_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      rec_q   <= '0;
      drop_q  <= '0;
    end else if (load_i && free) begin
      // A simultaneous drain and load keeps valid high with the new record.
      rec_q   <= rec_i;
      valid_q <= 1'b1;
    end else begin
      // Here load_i implies a full slot with ready_i low: held record untouched.
      if (load_i && (drop_q != '1)) drop_q <= drop_q + 16'd1;
      if (ready_i) valid_q <= 1'b0;
    end
  end

  assign valid_o      = valid_q;
  assign rec_o        = rec_q;
  assign drop_count_o = drop_q;

endmodule

// File: rtl/v1_peak_detector.sv
// ---------------------------------------------------------------------------
// v1_peak_detector
// Threshold-crossing pulse detector behind the v1 trapezoidal filter. Tracks
// the pulse maximum and the timestamp of its first occurrence, then hands one
// record per pulse to the readout stage over valid/ready, followed by a
// programmable hold-off.
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   in_data        : filtered sample (signed), one per clk
//   out_amplitude  : pulse maximum (signed)
//   out_timestamp  : timestamp of first sample at the maximum
//   out_valid      : record available; out_ready accepts it
//   drop_count     : events lost to a full output slot (saturating)
//   pileup_count   : events rejected as pile-up (saturating)
//   busy           : FSM not in IDLE
//
// Build option: define V1_PEAK_PILEUP_REJECT_EN to reject pulses that stay
// above threshold for MAX_WIDTH samples; otherwise pileup_count reads 0.
// ---------------------------------------------------------------------------
module v1_peak_detector
  import package_settings::*;
  import v1_peak_params::*;
#(
  parameter int THRESHOLD      = THRESHOLD_DEF,
  parameter int HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEF,
  parameter int TS_W           = TS_W_DEF,
  parameter int MAX_WIDTH      = MAX_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SIZE_FILTER_DATA-1:0] in_data,
  output logic [SIZE_FILTER_DATA-1:0] out_amplitude,
  output logic [TS_W-1:0]             out_timestamp,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [15:0]                 drop_count,
  output logic [15:0]                 pileup_count,
  output logic                        busy
);

  typedef struct packed {
    logic signed [SIZE_FILTER_DATA-1:0] amplitude;
    logic        [TS_W-1:0]             timestamp;
  } rec_t;

  localparam logic signed [SIZE_FILTER_DATA-1:0] THR     = SIZE_FILTER_DATA'(THRESHOLD);
  localparam logic        [CNT_W-1:0]            HO_LOAD = CNT_W'(HOLDOFF_CYCLES);

  logic signed [SIZE_FILTER_DATA-1:0] din_s;
  logic signed [SIZE_FILTER_DATA-1:0] max_q;
  logic        [TS_W-1:0]             ts_q, ts_d, max_ts_q;
  logic        [CNT_W-1:0]            width_q, width_inc, hold_q;
  peak_state_t                        state_q;
  logic                               above;
  rec_t                               rec_in, rec_out;

  assign din_s     = $signed(in_data);
  assign above     = din_s > THR;
  assign width_inc = (width_q == '1) ? width_q : width_q + CNT_W'(1);

  // Free-running timestamp; wrap is harmless.
  assign ts_d = ts_q + TS_W'(1);
  always_ff @(posedge clk) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_d;
  end

`ifdef V1_PEAK_PILEUP_REJECT_EN
  logic        pile_q;
  logic [15:0] pileup_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      max_q    <= '0;
      max_ts_q <= '0;
      width_q  <= '0;
      hold_q   <= '0;
`ifdef V1_PEAK_PILEUP_REJECT_EN
      pile_q   <= 1'b0;
      pileup_q <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (above) begin
            max_q    <= din_s;
            max_ts_q <= ts_q;
            width_q  <= CNT_W'(1);
            state_q  <= ARMED;
          end
        end
        ARMED: begin
          width_q <= width_inc;
          if (!above) begin
            // The closing sample never competes for the maximum.
            state_q <= EMIT;
          end else begin
            // Strict compare keeps the earliest sample on a plateau.
            if (din_s > max_q) begin
              max_q    <= din_s;
              max_ts_q <= ts_q;
            end
`ifdef V1_PEAK_PILEUP_REJECT_EN
            if (32'(width_inc) >= 32'(MAX_WIDTH)) begin
              pile_q  <= 1'b1;
              hold_q  <= HO_LOAD;
              state_q <= (HOLDOFF_CYCLES == 0) ? WAIT_LOW : HOLDOFF;
              if (pileup_q != '1) pileup_q <= pileup_q + 16'd1;
            end
`endif
          end
        end
        EMIT: begin
          // The output slot samples state_q == EMIT for its load strobe.
          hold_q  <= HO_LOAD;
          state_q <= (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
        end
        HOLDOFF: begin
          // Loaded with N, this state lasts exactly N cycles.
          if (hold_q <= CNT_W'(1)) begin
`ifdef V1_PEAK_PILEUP_REJECT_EN
            state_q <= pile_q ? WAIT_LOW : IDLE;
`else
            state_q <= IDLE;
`endif
          end
          if (hold_q != '0) hold_q <= hold_q - CNT_W'(1);
        end
        WAIT_LOW: begin
          if (!above) begin
            state_q <= IDLE;
`ifdef V1_PEAK_PILEUP_REJECT_EN
            pile_q  <= 1'b0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef V1_PEAK_PILEUP_REJECT_EN
  assign pileup_count = pileup_q;
`else
  assign pileup_count = '0;
  logic unused_maxw;
  assign unused_maxw = (MAX_WIDTH != 0);
`endif

  assign rec_in = '{amplitude: max_q, timestamp: max_ts_q};

  v1_peak_out_slot #(
    .rec_t (rec_t)
  ) u_slot (
    .clk          (clk),
    .reset        (reset),
    .load_i       (state_q == EMIT),
    .rec_i        (rec_in),
    .ready_i      (out_ready),
    .valid_o      (out_valid),
    .rec_o        (rec_out),
    .drop_count_o (drop_count)
  );

  assign out_amplitude = rec_out.amplitude;
  assign out_timestamp = rec_out.timestamp;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_v1_peak_detector.sv
module tb_v1_peak_detector;
  import package_settings::*;

  logic                        clk;
  logic                        reset;
  logic [SIZE_FILTER_DATA-1:0] in_data;
  logic [SIZE_FILTER_DATA-1:0] out_amplitude;
  logic [31:0]                 out_timestamp;
  logic                        out_valid;
  logic                        out_ready;
  logic [15:0]                 drop_count;
  logic [15:0]                 pileup_count;
  logic                        busy;

  int total = 0;
  int bad   = 0;

  v1_peak_detector #(
    .THRESHOLD      (100),
    .HOLDOFF_CYCLES (8),
    .TS_W           (32),
    .MAX_WIDTH      (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_data       (in_data),
    .out_amplitude (out_amplitude),
    .out_timestamp (out_timestamp),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .drop_count    (drop_count),
    .pileup_count  (pileup_count),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one sample at the next posedge; return at the following negedge.
  task automatic drive(input int v);
    in_data = SIZE_FILTER_DATA'(v);
    @(negedge clk);
  endtask

  // After this, the k-th sample driven is taken when ts == k.
  task automatic do_reset();
    reset   = 1'b1;
    in_data = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    do_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0d exp=0", out_valid); end
    total++; if (out_amplitude !== 16'd0) begin bad++; $display("FAIL rst_amp got=%0d exp=0", out_amplitude); end
    total++; if (out_timestamp !== 32'd0) begin bad++; $display("FAIL rst_ts got=%0d exp=0", out_timestamp); end
    total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL rst_drop got=%0d exp=0", drop_count); end
    total++; if (pileup_count !== 16'd0) begin bad++; $display("FAIL rst_pileup got=%0d exp=0", pileup_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0d exp=0", busy); end
  endtask

  task automatic test_single_pulse();
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 10; i++) drive(0);
    drive(0); drive(50); drive(150);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL sp_busy got=%0d exp=1", busy); end
    drive(300); drive(250); drive(120); drive(90);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sp_early_valid got=%0d exp=0", out_valid); end
    drive(0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sp_valid got=%0d exp=1", out_valid); end
    total++; if (out_amplitude !== 16'd300) begin bad++; $display("FAIL sp_amp got=%0d exp=300", out_amplitude); end
    total++; if (out_timestamp !== 32'd13) begin bad++; $display("FAIL sp_ts got=%0d exp=13", out_timestamp); end
    drive(0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sp_valid_clr got=%0d exp=0", out_valid); end
  endtask

  task automatic test_plateau();
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 20; i++) drive(0);
    drive(200); drive(300); drive(300); drive(300); drive(50);
    drive(0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pl_valid got=%0d exp=1", out_valid); end
    total++; if (out_amplitude !== 16'd300) begin bad++; $display("FAIL pl_amp got=%0d exp=300", out_amplitude); end
    total++; if (out_timestamp !== 32'd21) begin bad++; $display("FAIL pl_ts got=%0d exp=21", out_timestamp); end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    do_reset();
    drive(200); drive(300); drive(0);   // ts 0..2, EMIT at ts 3
    drive(0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid1 got=%0d exp=1", out_valid); end
    total++; if (out_amplitude !== 16'd300) begin bad++; $display("FAIL bp_amp1 got=%0d exp=300", out_amplitude); end
    total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL bp_drop0 got=%0d exp=0", drop_count); end
    for (int i = 0; i < 12; i++) drive(0); // ts 4..15
    drive(400); drive(0); drive(0);        // ts 16..18, EMIT at ts 18
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid2 got=%0d exp=1", out_valid); end
    total++; if (out_amplitude !== 16'd300) begin bad++; $display("FAIL bp_amp_held got=%0d exp=300", out_amplitude); end
    total++; if (out_timestamp !== 32'd1) begin bad++; $display("FAIL bp_ts_held got=%0d exp=1", out_timestamp); end
    total++; if (drop_count !== 16'd1) begin bad++; $display("FAIL bp_drop got=%0d exp=1", drop_count); end
    out_ready = 1'b1;
    drive(0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_clr got=%0d exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    do_reset();
    drive(200); drive(300); drive(0); drive(0);
    for (int i = 0; i < 12; i++) drive(0);
    drive(400); drive(0);             // ts 16, 17
    out_ready = 1'b1;                 // drain and reload on the same edge (ts 18)
    drive(0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bb_valid got=%0d exp=1", out_valid); end
    total++; if (out_amplitude !== 16'd400) begin bad++; $display("FAIL bb_amp got=%0d exp=400", out_amplitude); end
    total++; if (out_timestamp !== 32'd16) begin bad++; $display("FAIL bb_ts got=%0d exp=16", out_timestamp); end
    total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL bb_drop got=%0d exp=0", drop_count); end
    drive(0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bb_valid_clr got=%0d exp=0", out_valid); end
  endtask

  task automatic test_holdoff();
    out_ready = 1'b1;
    do_reset();
    drive(200); drive(0);             // pulse ends at ts 1
    drive(0);                         // EMIT at ts 2
    total++; if (out_amplitude !== 16'd200) begin bad++; $display("FAIL ho_amp1 got=%0d exp=200", out_amplitude); end
    drive(0); drive(250); drive(250); // crossing at ts 4 = end + 3
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ho_busy got=%0d exp=1", busy); end
    drive(0);
    for (int i = 0; i < 6; i++) drive(0); // ts 7..12
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ho_ignored got=%0d exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ho_idle got=%0d exp=0", busy); end
    drive(260); drive(0);             // crossing at ts 13 = end + 12
    drive(0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ho_valid2 got=%0d exp=1", out_valid); end
    total++; if (out_amplitude !== 16'd260) begin bad++; $display("FAIL ho_amp2 got=%0d exp=260", out_amplitude); end
    total++; if (out_timestamp !== 32'd13) begin bad++; $display("FAIL ho_ts2 got=%0d exp=13", out_timestamp); end
  endtask

  // Pulse ends at ts 1: ts 10 is the last ignored sample, ts 11 re-arms.
  task automatic test_holdoff_boundary();
    out_ready = 1'b1;
    do_reset();
    drive(200); drive(0);
    for (int i = 0; i < 8; i++) drive(0); // ts 2..9
    drive(150); drive(180); drive(0);     // ts 10, 11, 12
    drive(0);                             // EMIT at ts 13
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hb_valid got=%0d exp=1", out_valid); end
    total++; if (out_amplitude !== 16'd180) begin bad++; $display("FAIL hb_amp got=%0d exp=180", out_amplitude); end
    total++; if (out_timestamp !== 32'd11) begin bad++; $display("FAIL hb_ts got=%0d exp=11", out_timestamp); end
  endtask

  task automatic test_reset_mid_pulse();
    out_ready = 1'b1;
    do_reset();
    drive(200); drive(300);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rm_busy_armed got=%0d exp=1", busy); end
    reset   = 1'b1;
    in_data = '0;
    @(negedge clk);
    reset = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%0d exp=0", busy); end
    total++; if (out_amplitude !== 16'd0) begin bad++; $display("FAIL rm_amp got=%0d exp=0", out_amplitude); end
    total++; if (out_timestamp !== 32'd0) begin bad++; $display("FAIL rm_ts got=%0d exp=0", out_timestamp); end
    drive(0); drive(0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_no_record got=%0d exp=0", out_valid); end
    drive(120); drive(0); drive(0);   // ts 2 arms, EMIT at ts 4
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rm_valid got=%0d exp=1", out_valid); end
    total++; if (out_amplitude !== 16'd120) begin bad++; $display("FAIL rm_amp2 got=%0d exp=120", out_amplitude); end
    total++; if (out_timestamp !== 32'd2) begin bad++; $display("FAIL rm_ts2 got=%0d exp=2", out_timestamp); end
  endtask

`ifdef V1_PEAK_PILEUP_REJECT_EN
  task automatic test_pileup();
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 16; i++) drive(500); // width hits 4 at ts 3; hold-off ts 4..11
    total++; if (pileup_count !== 16'd1) begin bad++; $display("FAIL pu_count got=%0d exp=1", pileup_count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pu_valid got=%0d exp=0", out_valid); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL pu_wait_low got=%0d exp=1", busy); end
    drive(50);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL pu_idle got=%0d exp=0", busy); end
    drive(500);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL pu_rearm got=%0d exp=1", busy); end
  endtask
`else
  task automatic test_long_pulse();
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) drive(500);
    drive(0); drive(0);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lp_valid got=%0d exp=1", out_valid); end
    total++; if (out_amplitude !== 16'd500) begin bad++; $display("FAIL lp_amp got=%0d exp=500", out_amplitude); end
    total++; if (out_timestamp !== 32'd0) begin bad++; $display("FAIL lp_ts got=%0d exp=0", out_timestamp); end
    total++; if (pileup_count !== 16'd0) begin bad++; $display("FAIL lp_pileup got=%0d exp=0", pileup_count); end
  endtask
`endif

  initial begin
    reset     = 1'b1;
    in_data   = '0;
    out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_pulse();
    test_plateau();
    test_back_pressure();
    test_back_to_back();
    test_holdoff();
    test_holdoff_boundary();
    test_reset_mid_pulse();
`ifdef V1_PEAK_PILEUP_REJECT_EN
    test_pileup();
`else
    test_long_pulse();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
